// File: rtl/uart_tx.sv
// uart_tx: UART frame serialiser (start, DBIT data LSB first, optional parity under UART_TX_PARITY_EN, stop)
module uart_tx #(
  parameter int DBIT = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_tx_busy
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [5:0] S_BIT = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] S_STOP = 6'(STOP_TICKS - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);
  logic [2:0] state;
  logic [5:0] s;
  logic [2:0] n;
  logic [DBIT-1:0] b;
`ifdef UART_TX_PARITY_EN
  logic p;
`endif
  assign o_tx_busy = state != IDLE;
  // Frame FSM: ticks advance bit timing, the line is registered and moves on the terminating tick
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      o_tx <= 1'b1;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      p <= 1'b0;
`endif
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (i_tx_start) begin
            b <= i_data;
            s <= '0;
            state <= START;
            o_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            p <= (^i_data) ^ PARITY_ODD;
`endif
          end
        end
        START: if (i_tick) begin
          if (s == S_BIT) begin
            s <= '0;
            n <= '0;
            state <= DATA;
            o_tx <= b[0];
          end else s <= s + 6'd1;
        end
        DATA: if (i_tick) begin
          if (s == S_BIT) begin
            s <= '0;
            b <= b >> 1;
            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              o_tx <= p;
`else
              state <= STOP;
              o_tx <= 1'b1;
`endif
            end else begin
              n <= n + 3'd1;
              o_tx <= b[1];
            end
          end else s <= s + 6'd1;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (i_tick) begin
          if (s == S_BIT) begin
            s <= '0;
            state <= STOP;
            o_tx <= 1'b1;
          end else s <= s + 6'd1;
        end
`endif
        STOP: begin
          o_tx <= 1'b1;
          if (i_tick) begin
            if (s == S_STOP) begin
              s <= '0;
              state <= IDLE;
              o_tx_done <= 1'b1;
            end else s <= s + 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          o_tx <= 1'b1;
        end
      endcase
    end
  end
endmodule
